buck_switch_ctrl: RTL

BUCK_SWITCH_CTRL -- requirements
Module: buck_switch_ctrl

---
 rtl/buck_switch_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/buck_switch_ctrl.sv
// Synchronous buck converter switch sequencer. It drives the high-side (P) and
// low-side (N) switches with ack-qualified dead time, a minimum on-time, an
// overcurrent cut-off and a sticky fault for ack timeouts or switch overlap.
module buck_switch_ctrl #(
  parameter int DEAD_CYC = 4,
  parameter int MIN_ON   = 8,
  parameter int ACK_TO   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pwm_req,
  input  logic       oc,
  input  logic       zc,
  input  logic       gp_ack,
  input  logic       gn_ack,
  output logic       gp,
  output logic       gn,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    P_ON_WAIT  = 3'd1,
    P_ON       = 3'd2,
    P_OFF_WAIT = 3'd3,
    DEAD_N     = 3'd4,
    N_ON       = 3'd5,
    N_OFF_WAIT = 3'd6,
    DEAD_P     = 3'd7
  } state_t;

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);
  localparam logic [7:0] MIN_LOAD  = 8'(MIN_ON - 1);
  localparam logic [9:0] TO_LAST   = 10'(ACK_TO - 1);

  state_t     cur;
  state_t     nxt;
  logic       fault_nxt;
  logic [7:0] dead_cnt;
  logic [7:0] min_cnt;
  logic [9:0] to_cnt;
  logic       dead_done;
  logic       to_hit;
  logic       in_wait;
  logic       in_dead;

  assign dead_done = (dead_cnt >= DEAD_LAST);
  assign to_hit    = (to_cnt >= TO_LAST);
  assign in_wait   = (cur == P_ON_WAIT) || (cur == P_OFF_WAIT) || (cur == N_OFF_WAIT);
  assign in_dead   = (cur == DEAD_P) || (cur == DEAD_N);
  assign state     = cur;

  always_comb begin
    nxt       = cur;
    fault_nxt = fault;
    if (fault) begin
      nxt = IDLE;
    end else if (gp_ack && gn_ack) begin
      fault_nxt = 1'b1;
      nxt       = IDLE;
    end else begin
      case (cur)
        IDLE: begin
          if (en && pwm_req && !oc && !gp_ack && !gn_ack) nxt = DEAD_P;
        end
        DEAD_P: begin
          // A disable during dead time must not launch a new P phase.
          if (!en)            nxt = IDLE;
          else if (dead_done) nxt = P_ON_WAIT;
        end
        P_ON_WAIT: begin
          if (oc)          nxt = P_OFF_WAIT;
          else if (gp_ack) nxt = P_ON;
          else if (to_hit) begin
            fault_nxt = 1'b1;
            nxt       = IDLE;
          end
        end
        P_ON: begin
          if (oc)                                        nxt = P_OFF_WAIT;
          else if (min_cnt == 8'd0 && (!pwm_req || !en)) nxt = P_OFF_WAIT;
        end
        P_OFF_WAIT: begin
          if (!gp_ack) nxt = DEAD_N;
          else if (to_hit) begin
            fault_nxt = 1'b1;
            nxt       = IDLE;
          end
        end
        DEAD_N: begin
          if (dead_done) nxt = N_ON;
        end
        N_ON: begin
          // zc and a new period both end N conduction; the exit path is shared.
          if (zc || pwm_req) nxt = N_OFF_WAIT;
        end
        N_OFF_WAIT: begin
          if (!gn_ack) nxt = (en && pwm_req && !oc) ? DEAD_P : IDLE;
          else if (to_hit) begin
            fault_nxt = 1'b1;
            nxt       = IDLE;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= IDLE;
      fault    <= 1'b0;
      gp       <= 1'b0;
      gn       <= 1'b0;
      dead_cnt <= 8'd0;
      min_cnt  <= 8'd0;
      to_cnt   <= 10'd0;
    end else begin
      cur   <= nxt;
      fault <= fault_nxt;
      // Commands decode the next state so they change with the state register.
      gp    <= (nxt == P_ON_WAIT) || (nxt == P_ON);
      gn    <= (nxt == N_ON);

      if (nxt != cur)                     dead_cnt <= 8'd0;
      else if (in_dead && dead_cnt != 8'hFF) dead_cnt <= dead_cnt + 8'd1;

      if (nxt != cur)                     to_cnt <= 10'd0;
      else if (in_wait && to_cnt != 10'h3FF) to_cnt <= to_cnt + 10'd1;

      // Loaded with MIN_ON-1 so P_ON lasts at least MIN_ON cycles from the ack.
      if (cur == P_ON_WAIT && nxt == P_ON)    min_cnt <= MIN_LOAD;
      else if (cur == P_ON && min_cnt != 8'd0) min_cnt <= min_cnt - 8'd1;
      else if (cur != P_ON)                   min_cnt <= 8'd0;
    end
  end

endmodule
